// File: rtl/dvd_pkg.sv
// Shared types and constants for the bouncing DVD logo engine.
// Optional feature macro: DVD_CORNER_FLASH_EN (flash FSM states live here).
package dvd_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int PAL_N     = 7;

    typedef logic [5:0] color_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLASH = 1'b1
    } fsm_t;

    // Seven-entry RRGGBB palette cycled on every bounce.
    function automatic color_t palette(input logic [2:0] idx);
        color_t c;
        case (idx)
            3'd0:    c = 6'h30;
            3'd1:    c = 6'h0C;
            3'd2:    c = 6'h03;
            3'd3:    c = 6'h3C;
            3'd4:    c = 6'h33;
            3'd5:    c = 6'h0F;
            3'd6:    c = 6'h3F;
            default: c = 6'h30;
        endcase
        return c;
    endfunction

    // Palette index successor, wrapping 6 -> 0.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx == 3'(PAL_N - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/dvd_axis_bounce.sv
// One axis of logo motion: position/direction register with edge reflection.
// hit is combinational and reports whether the pending step would touch an edge.
module dvd_axis_bounce
    import dvd_pkg::*;
#(
    parameter int MAX   = 512,
    parameter int SPEED = 1,
    parameter int START = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [9:0] pos,
    output logic       hit
);

    localparam logic [10:0] MAX_W    = 11'(MAX);
    localparam logic [10:0] SPEED_W  = 11'(SPEED);
    localparam logic [9:0]  SPEED_10 = 10'(SPEED);
    localparam logic [9:0]  MAX_10   = 10'(MAX);
    localparam logic [9:0]  START_10 = 10'(START);

    logic        dir_neg;
    logic        dir_neg_nxt;
    logic [9:0]  pos_nxt;
    logic [10:0] sum;

    // Next position/direction; the sum is 11 bits wide so it can never wrap.
    always_comb begin
        sum         = {1'b0, pos} + SPEED_W;
        pos_nxt     = pos;
        dir_neg_nxt = dir_neg;
        hit         = 1'b0;
        if (!dir_neg) begin
            if (sum >= MAX_W) begin
                pos_nxt     = MAX_10;
                dir_neg_nxt = 1'b1;
                hit         = 1'b1;
            end else begin
                pos_nxt = sum[9:0];
            end
        end else begin
            if ({1'b0, pos} <= SPEED_W) begin
                pos_nxt     = 10'd0;
                dir_neg_nxt = 1'b0;
                hit         = 1'b1;
            end else begin
                pos_nxt = pos - SPEED_10;
            end
        end
    end

    // Position and direction advance only on a step.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos     <= START_10;
            dir_neg <= 1'b0;
        end else if (step) begin
            pos     <= pos_nxt;
            dir_neg <= dir_neg_nxt;
        end
    end

endmodule

// File: rtl/dvd_bounce_engine.sv
// Per-frame motion engine for the bouncing DVD logo: steps both axes,
// reports edge/corner hits and selects the logo colour.
// Optional feature macro: DVD_CORNER_FLASH_EN (white/black flash after a corner hit).
module dvd_bounce_engine
    import dvd_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int LOGO_W  = 128,
    parameter int LOGO_H  = 64,
    parameter int SPEED   = 1,
    parameter int START_X = 37,
    parameter int START_Y = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       pause,
    output logic [9:0] logo_x,
    output logic [9:0] logo_y,
    output color_t     color,
    output logic       bounce,
    output logic       corner_hit
);

    localparam int XMAX = H_RES - LOGO_W;
    localparam int YMAX = V_RES - LOGO_H;

    logic       step;
    logic       hit_x;
    logic       hit_y;
    logic       any_hit;
    logic       both_hit;
    logic [2:0] pal_idx;
    logic [2:0] pal_idx_nxt;

    assign step     = frame_tick & ~pause;
    assign any_hit  = hit_x | hit_y;
    assign both_hit = hit_x & hit_y;

    dvd_axis_bounce #(
        .MAX   (XMAX),
        .SPEED (SPEED),
        .START (START_X)
    ) u_axis_x (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .pos  (logo_x),
        .hit  (hit_x)
    );

    dvd_axis_bounce #(
        .MAX   (YMAX),
        .SPEED (SPEED),
        .START (START_Y)
    ) u_axis_y (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .pos  (logo_y),
        .hit  (hit_y)
    );

    // A corner counts as a single bounce, so the index moves by one at most.
    assign pal_idx_nxt = (step && any_hit) ? next_idx(pal_idx) : pal_idx;

    // Palette index register and the one-cycle hit pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pal_idx    <= 3'd0;
            bounce     <= 1'b0;
            corner_hit <= 1'b0;
        end else begin
            pal_idx    <= pal_idx_nxt;
            bounce     <= step & any_hit;
            corner_hit <= step & both_hit;
        end
    end

`ifdef DVD_CORNER_FLASH_EN
    localparam logic [5:0] FLASH_LEN = 6'd32;
    localparam color_t     COL_ON    = 6'h3F;
    localparam color_t     COL_OFF   = 6'h00;

    fsm_t       state;
    fsm_t       state_nxt;
    logic [5:0] flash_cnt;
    logic [5:0] flash_cnt_nxt;
    color_t     color_nxt;

    // Flash FSM state, step counter and colour registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            flash_cnt <= 6'd0;
            color     <= palette(3'd0);
        end else begin
            state     <= state_nxt;
            flash_cnt <= flash_cnt_nxt;
            color     <= color_nxt;
        end
    end

    // Corner enters (or restarts) the flash; each later step toggles until the count runs out.
    always_comb begin
        state_nxt     = state;
        flash_cnt_nxt = flash_cnt;
        color_nxt     = color;
        if (step) begin
            if (both_hit) begin
                state_nxt     = ST_FLASH;
                flash_cnt_nxt = FLASH_LEN;
                color_nxt     = COL_ON;
            end else if (state == ST_FLASH) begin
                if (flash_cnt <= 6'd1) begin
                    state_nxt     = ST_RUN;
                    flash_cnt_nxt = 6'd0;
                    color_nxt     = palette(pal_idx_nxt);
                end else begin
                    flash_cnt_nxt = flash_cnt - 6'd1;
                    color_nxt     = (color == COL_ON) ? COL_OFF : COL_ON;
                end
            end else begin
                color_nxt = palette(pal_idx_nxt);
            end
        end
    end
`else
    // Colour follows the palette index, refreshed on each step.
    always_ff @(posedge clk) begin
        if (rst) begin
            color <= palette(3'd0);
        end else if (step) begin
            color <= palette(pal_idx_nxt);
        end
    end
`endif

endmodule
